// File: rtl/phase_pulse_gen.sv
// Multi-phase strobe generator. A period counter runs 0..max, either
// free-running or one period per start, and each channel raises its pulse
// over a programmable window [ofs, ofs+wid-1] clipped at max. Configuration
// is written to a shadow copy and made live only on a period boundary (or
// straight away while the counter is stopped), so a strobe never changes
// shape in the middle of a period.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | one-shot mode waiting for start; also parked here in
//           | continuous mode, where the state is not used
//   ST_RUN  | one-shot period in progress, count steps 0..max
module phase_pulse_gen #(
   parameter int                       NUM_PH  = 3,
   parameter int                       CNT_W   = 8,
   parameter logic [CNT_W-1:0]         RST_MAX = 10,
   parameter logic [NUM_PH*CNT_W-1:0]  RST_OFS = {8'd6, 8'd4, 8'd2},
   parameter logic [CNT_W-1:0]         RST_WID = 1
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_en,
   input  logic                       i_start,
   input  logic                       i_cfg_wr,
   input  logic [CNT_W-1:0]           i_cfg_max,
   input  logic [NUM_PH*CNT_W-1:0]    i_cfg_ofs,
   input  logic [CNT_W-1:0]           i_cfg_wid,
   input  logic                       i_cfg_mode,
   output logic [NUM_PH-1:0]          o_pulse,
   output logic [CNT_W-1:0]           o_count,
   output logic                       o_wrap,
   output logic                       o_active,
   output logic                       o_done,
   output logic                       o_cfg_pending,
   output logic                       o_cfg_ack,
   output logic                       o_cfg_err
);

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   state_t                     r_state, w_state;
   logic [CNT_W-1:0]           r_count, w_count;
   logic                       r_active, w_active;
   // r_fresh: the held count has not yet been shown in an active cycle, so
   // the next enabled edge displays it instead of stepping past it.
   logic                       r_fresh, w_fresh;
   logic                       r_done, w_done;
   logic [NUM_PH-1:0]          r_pulse, w_pulse;
   logic                       r_wrap, w_wrap;
   logic                       r_pend, w_pend;
   logic                       r_ack, r_err;

   logic [CNT_W-1:0]           r_max, w_max;
   logic [NUM_PH*CNT_W-1:0]    r_ofs, w_ofs;
   logic [CNT_W-1:0]           r_wid, w_wid;
   logic                       r_mode, w_mode;

   logic [CNT_W-1:0]           r_sh_max;
   logic [NUM_PH*CNT_W-1:0]    r_sh_ofs;
   logic [CNT_W-1:0]           r_sh_wid;
   logic                       r_sh_mode;

   logic                       w_cfg_ok;
   logic                       w_wr_ok;
   logic                       w_wr_bad;
   logic                       w_boundary;
   logic                       w_apply;

   // Validate an incoming config word: nonzero max, every offset within it.
   always_comb begin
      w_cfg_ok = (i_cfg_max != '0);
      for (int i = 0; i < NUM_PH; i++) begin
         if (i_cfg_ofs[i*CNT_W +: CNT_W] > i_cfg_max) w_cfg_ok = 1'b0;
      end
   end

   assign w_wr_ok  = i_cfg_wr && w_cfg_ok;
   assign w_wr_bad = i_cfg_wr && !w_cfg_ok;

   // Apply point: end of a period while running, any edge while stopped.
   // A frozen one-shot run still counts as running so it is not cut short.
   always_comb begin
      if (r_mode) begin
         w_boundary = (r_state == ST_RUN) ? (i_en && (r_count == r_max)) : 1'b1;
      end else begin
         w_boundary = !r_active || (r_count == r_max);
      end
   end

   assign w_apply = r_pend && w_boundary;

   // Next state of the counter, run state and live configuration.
   always_comb begin
      w_state  = r_state;
      w_count  = r_count;
      w_active = r_active;
      w_fresh  = r_fresh;
      w_done   = 1'b0;
      w_max    = r_max;
      w_ofs    = r_ofs;
      w_wid    = r_wid;
      w_mode   = r_mode;

      if (!r_mode) begin
         w_state  = ST_IDLE;
         w_active = i_en;
         if (i_en) begin
            w_fresh = 1'b0;
            if (!r_fresh) w_count = (r_count == r_max) ? '0 : r_count + 1'b1;
         end
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_count  = '0;
               w_active = 1'b0;
               w_fresh  = 1'b1;
               if (i_en && i_start) begin
                  w_state  = ST_RUN;
                  w_active = 1'b1;
                  w_fresh  = 1'b0;
               end
            end
            ST_RUN: begin
               w_active = i_en;
               if (i_en) begin
                  if (r_count == r_max) begin
                     w_count  = '0;
                     w_done   = 1'b1;
                     w_state  = ST_IDLE;
                     w_active = 1'b0;
                     w_fresh  = 1'b1;
                     // back-to-back start on the edge that ends the period
                     if (i_start) begin
                        w_state  = ST_RUN;
                        w_active = 1'b1;
                        w_fresh  = 1'b0;
                     end
                  end else begin
                     w_count = r_count + 1'b1;
                  end
               end
            end
         endcase
      end

      if (w_apply) begin
         w_max   = r_sh_max;
         w_ofs   = r_sh_ofs;
         w_wid   = r_sh_wid;
         w_mode  = r_sh_mode;
         w_count = '0;
         if (!r_sh_mode) begin
            w_state  = ST_IDLE;
            w_active = i_en;
            w_fresh  = !i_en;
         end else if (!r_mode) begin
            w_state  = ST_IDLE;
            w_active = 1'b0;
            w_fresh  = 1'b1;
         end
      end
   end

   // Pulse windows and wrap flag, evaluated on the next count and next live
   // config so strobes move on the same edge as the counter.
   always_comb begin
      w_pulse = '0;
      for (int i = 0; i < NUM_PH; i++) begin
         w_pulse[i] = w_active
            && ({1'b0, w_count} >= {1'b0, w_ofs[i*CNT_W +: CNT_W]})
            && ({1'b0, w_count} < ({1'b0, w_ofs[i*CNT_W +: CNT_W]} + {1'b0, w_wid}))
            && (w_count <= w_max);
      end
      w_wrap = w_active && (w_count == w_max);
   end

   // A new accepted write always ends up pending, even on an apply edge.
   assign w_pend = w_wr_ok ? 1'b1 : (w_apply ? 1'b0 : r_pend);

   // State, outputs, live and shadow config registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= ST_IDLE;
         r_count   <= '0;
         r_active  <= 1'b0;
         r_fresh   <= 1'b1;
         r_done    <= 1'b0;
         r_pulse   <= '0;
         r_wrap    <= 1'b0;
         r_pend    <= 1'b0;
         r_ack     <= 1'b0;
         r_err     <= 1'b0;
         r_max     <= RST_MAX;
         r_ofs     <= RST_OFS;
         r_wid     <= RST_WID;
         r_mode    <= 1'b0;
         r_sh_max  <= RST_MAX;
         r_sh_ofs  <= RST_OFS;
         r_sh_wid  <= RST_WID;
         r_sh_mode <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_count  <= w_count;
         r_active <= w_active;
         r_fresh  <= w_fresh;
         r_done   <= w_done;
         r_pulse  <= w_pulse;
         r_wrap   <= w_wrap;
         r_pend   <= w_pend;
         r_ack    <= w_apply;
         r_err    <= w_wr_bad;
         r_max    <= w_max;
         r_ofs    <= w_ofs;
         r_wid    <= w_wid;
         r_mode   <= w_mode;
         if (w_wr_ok) begin
            r_sh_max  <= i_cfg_max;
            r_sh_ofs  <= i_cfg_ofs;
            r_sh_wid  <= i_cfg_wid;
            r_sh_mode <= i_cfg_mode;
         end
      end
   end

   assign o_pulse       = r_pulse;
   assign o_count       = r_count;
   assign o_wrap        = r_wrap;
   assign o_active      = r_active;
   assign o_done        = r_done;
   assign o_cfg_pending = r_pend;
   assign o_cfg_ack     = r_ack;
   assign o_cfg_err     = r_err;

endmodule

// File: tb/tb_phase_pulse_gen.sv
// Directed bench for phase_pulse_gen. Each step pushes the expected output
// word for the coming cycle onto a scoreboard queue; one cycle later the
// observed outputs are popped against it.
module tb_phase_pulse_gen;

   logic        clk = 1'b0;
   logic        rst, en, start, cfg_wr, cfg_mode;
   logic [7:0]  cfg_max, cfg_wid;
   logic [23:0] cfg_ofs;
   logic [2:0]  pulse;
   logic [7:0]  count;
   logic        wrap, active, done, cfg_pending, cfg_ack, cfg_err;

   int n_total = 0;
   int n_pass  = 0;

   typedef struct {
      string       tag;
      logic [16:0] val;
   } exp_t;

   exp_t q_exp[$];

   always #5 clk = ~clk;

   phase_pulse_gen dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_en          (en),
      .i_start       (start),
      .i_cfg_wr      (cfg_wr),
      .i_cfg_max     (cfg_max),
      .i_cfg_ofs     (cfg_ofs),
      .i_cfg_wid     (cfg_wid),
      .i_cfg_mode    (cfg_mode),
      .o_pulse       (pulse),
      .o_count       (count),
      .o_wrap        (wrap),
      .o_active      (active),
      .o_done        (done),
      .o_cfg_pending (cfg_pending),
      .o_cfg_ack     (cfg_ack),
      .o_cfg_err     (cfg_err)
   );

   // default channels: ofs 2/4/6, width 1
   function automatic logic [2:0] dpul(input int c);
      return {c == 6, c == 4, c == 2};
   endfunction

   // ch0 ofs 7, ch1 ofs 3, ch2 ofs 0, width 2, max 7
   function automatic logic [2:0] npul(input int c);
      return {c <= 1, (c == 3) || (c == 4), c == 7};
   endfunction

   task automatic push(input string tag, input int c, input logic [2:0] p,
                       input logic w, input logic a, input logic d,
                       input logic pe, input logic ak, input logic er);
      exp_t e;
      e.tag = tag;
      e.val = {c[7:0], p, w, a, d, pe, ak, er};
      q_exp.push_back(e);
   endtask

   task automatic compare();
      exp_t        e;
      logic [16:0] obs;
      n_total++;
      if (q_exp.size() == 0) begin
         $error("FAIL scoreboard_empty: observed no expectation, required one at %0t", $time);
      end else begin
         e   = q_exp.pop_front();
         obs = {count, pulse, wrap, active, done, cfg_pending, cfg_ack, cfg_err};
         assert (obs === e.val) n_pass++;
         else $error("FAIL %s: observed cnt=%0d pul=%b w/a/d/p/k/e=%b required cnt=%0d pul=%b w/a/d/p/k/e=%b at %0t",
                     e.tag, obs[16:9], obs[8:6], obs[5:0], e.val[16:9], e.val[8:6], e.val[5:0], $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      compare();
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; start = 1'b0; cfg_wr = 1'b0; cfg_mode = 1'b0;
      cfg_max = '0; cfg_ofs = '0; cfg_wid = '0;
      #12;
      push("reset", 0, 3'b000, 0, 0, 0, 0, 0, 0); compare();
      push("reset_hold", 0, 3'b000, 0, 0, 0, 0, 0, 0); cyc();
      rst = 1'b0; en = 1'b1;

      // two default periods: 11 cycles, pulses at 2/4/6, wrap at 10
      for (int k = 0; k < 22; k++) begin
         push("default", k % 11, dpul(k % 11), (k % 11) == 10, 1, 0, 0, 0, 0); cyc();
      end
      for (int k = 0; k < 6; k++) begin
         push("pre_write", k, dpul(k), 0, 1, 0, 0, 0, 0); cyc();
      end

      // mid-period write: stays pending until the old period ends
      cfg_wr = 1'b1; cfg_max = 8'd7; cfg_ofs = {8'd0, 8'd3, 8'd7}; cfg_wid = 8'd2; cfg_mode = 1'b0;
      push("write_pending", 6, dpul(6), 0, 1, 0, 1, 0, 0); cyc();
      cfg_wr = 1'b0;
      for (int k = 7; k <= 10; k++) begin
         push("old_cfg", k, dpul(k), k == 10, 1, 0, 1, 0, 0); cyc();
      end
      for (int k = 0; k < 16; k++) begin
         push("new_cfg", k % 8, npul(k % 8), (k % 8) == 7, 1, 0, 0, k == 0, 0); cyc();
      end

      // switch to one-shot, max 4, channels at 0/2/4
      cfg_wr = 1'b1; cfg_max = 8'd4; cfg_ofs = {8'd4, 8'd2, 8'd0}; cfg_wid = 8'd1; cfg_mode = 1'b1;
      push("os_write", 0, npul(0), 0, 1, 0, 1, 0, 0); cyc();
      cfg_wr = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         push("os_pending", k, npul(k), k == 7, 1, 0, 1, 0, 0); cyc();
      end
      push("os_apply", 0, 3'b000, 0, 0, 0, 0, 1, 0); cyc();
      push("os_idle", 0, 3'b000, 0, 0, 0, 0, 0, 0); cyc();
      start = 1'b1;
      push("os_start", 0, 3'b001, 0, 1, 0, 0, 0, 0); cyc();
      start = 1'b0;
      push("os_run1", 1, 3'b000, 0, 1, 0, 0, 0, 0); cyc();
      start = 1'b1;
      push("os_run2_restart_ignored", 2, 3'b010, 0, 1, 0, 0, 0, 0); cyc();
      start = 1'b0;
      push("os_run3", 3, 3'b000, 0, 1, 0, 0, 0, 0); cyc();
      push("os_run4", 4, 3'b100, 1, 1, 0, 0, 0, 0); cyc();
      push("os_done", 0, 3'b000, 0, 0, 1, 0, 0, 0); cyc();
      push("os_idle_after", 0, 3'b000, 0, 0, 0, 0, 0, 0); cyc();
      push("os_idle_after2", 0, 3'b000, 0, 0, 0, 0, 0, 0); cyc();

      // rejected writes: offset beyond max, then max of zero
      cfg_wr = 1'b1; cfg_max = 8'd5; cfg_ofs = {8'd6, 8'd1, 8'd0}; cfg_wid = 8'd1; cfg_mode = 1'b0;
      push("err_ofs", 0, 3'b000, 0, 0, 0, 0, 0, 1); cyc();
      cfg_wr = 1'b0;
      push("err_clear", 0, 3'b000, 0, 0, 0, 0, 0, 0); cyc();
      cfg_wr = 1'b1; cfg_max = 8'd0; cfg_ofs = '0;
      push("err_max0", 0, 3'b000, 0, 0, 0, 0, 0, 1); cyc();
      cfg_wr = 1'b0;
      push("err_clear2", 0, 3'b000, 0, 0, 0, 0, 0, 0); cyc();

      // idle apply back to continuous defaults (offset equal to... within max)
      cfg_wr = 1'b1; cfg_max = 8'd10; cfg_ofs = {8'd6, 8'd4, 8'd2}; cfg_wid = 8'd1; cfg_mode = 1'b0;
      push("idle_pend", 0, 3'b000, 0, 0, 0, 1, 0, 0); cyc();
      cfg_wr = 1'b0;
      push("idle_apply", 0, 3'b000, 0, 1, 0, 0, 1, 0); cyc();
      for (int k = 1; k <= 3; k++) begin
         push("cont_run", k, dpul(k), 0, 1, 0, 0, 0, 0); cyc();
      end

      // freeze for three cycles at count 3
      en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         push("frozen", 3, 3'b000, 0, 0, 0, 0, 0, 0); cyc();
      end
      en = 1'b1;
      for (int k = 4; k <= 10; k++) begin
         push("resume", k, dpul(k), k == 10, 1, 0, 0, 0, 0); cyc();
      end
      for (int k = 0; k <= 4; k++) begin
         push("resume_next", k, dpul(k), 0, 1, 0, 0, 0, 0); cyc();
      end

      // pending config discarded by an asynchronous reset at count 5
      cfg_wr = 1'b1; cfg_max = 8'd3; cfg_ofs = {8'd1, 8'd1, 8'd1}; cfg_wid = 8'd1; cfg_mode = 1'b0;
      push("rst_pend", 5, dpul(5), 0, 1, 0, 1, 0, 0); cyc();
      cfg_wr = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      push("async_rst", 0, 3'b000, 0, 0, 0, 0, 0, 0); compare();
      @(posedge clk);
      #1;
      rst = 1'b0;
      push("rst_released", 0, 3'b000, 0, 0, 0, 0, 0, 0); compare();
      for (int k = 0; k < 13; k++) begin
         push("post_rst", k % 11, dpul(k % 11), (k % 11) == 10, 1, 0, 0, 0, 0); cyc();
      end

      n_total++;
      assert (q_exp.size() == 0) n_pass++;
      else $error("FAIL scoreboard_leftover: observed %0d entries, required 0", q_exp.size());

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/phase_pulse_gen.md
# phase_pulse_gen

Parametrised multi-phase pulse generator that drives the processor's per-step strobes (data-out, set-data, state-update, and further phases as needed). A free-running or one-shot period counter produces NUM_PH independent one-or-more-cycle pulses at programmable offsets. Period, offsets, pulse width and mode are reconfigurable at run time through shadow registers that take effect only on a period boundary, so strobes never glitch mid-period. With default parameters the block produces an 11-cycle period with single-cycle pulses at counts 2, 4 and 6.

## Interface
- NUM_PH, 3, number of phase channels (1..16)
- CNT_W, 8, counter/offset/width field width
- RST_MAX, 10, reset value of the period maximum (period = max+1)
- RST_OFS, {8'd6,8'd4,8'd2}, packed reset offsets; channel i at bits [i*CNT_W +: CNT_W]
- RST_WID, 1, reset pulse width for all channels
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  run enable; 0 freezes the counter and forces all pulses low
- start  in  1  one-shot trigger; used only in one-shot mode
- cfg_wr  in  1  single-cycle config write strobe
- cfg_max  in  CNT_W  new period maximum
- cfg_ofs  in  NUM_PH*CNT_W  new offsets, packed like RST_OFS
- cfg_wid  in  CNT_W  new pulse width (0 = all channels silent)
- cfg_mode  in  1  0 continuous, 1 one-shot
- pulse  out  NUM_PH  phase strobes
- count  out  CNT_W  current counter value
- wrap  out  1  high while count==max and active
- active  out  1  counter running
- done  out  1  one-cycle pulse after a one-shot period ends
- cfg_pending  out  1  valid config held in shadow, not yet applied
- cfg_ack  out  1  one-cycle pulse in the cycle the new config becomes live
- cfg_err  out  1  one-cycle pulse on a rejected cfg_wr

## Operation
- All outputs are registered. Reset values: count=0, pulse=0, wrap=0, done=0, cfg_pending=0, cfg_ack=0, cfg_err=0; active=0 before the first edge. Live config = RST_MAX/RST_OFS/RST_WID, mode continuous.
- Continuous mode: active=en. When active, count increments each cycle and returns from max to 0. With en=0, count holds and pulses are 0. Re-asserting en resumes from the held count.
- One-shot mode has states IDLE and RUN.
  - IDLE: count=0, active=0.
  - start=1 with en=1 in IDLE moves to RUN. The next cycle shows count=0, active=1.
  - RUN steps through 0..max, then returns to IDLE with done=1 for exactly one cycle.
  - start during RUN is ignored. en=0 during RUN freezes the counter; the period is not aborted.
- Pulse rule: pulse[i]=1 exactly in cycles where active=1 and ofs_i ≤ count ≤ min(ofs_i+wid−1, max). Windows never wrap past max.
- Config write checks:
  - Rejected if cfg_max=0 or any offset > cfg_max. A rejected write pulses cfg_err and leaves the shadow and pending state unchanged.
  - Accepted writes go to the shadow and set cfg_pending. A later accepted write overwrites the shadow.
- Config apply:
  - Occurs on the edge where count==max while active, or on the first edge after pending is set while not active.
  - At apply: live←shadow, cfg_pending←0, cfg_ack=1 for the following cycle.
  - A mode change on apply takes effect for the next period. Continuous→one-shot lands in IDLE; one-shot→continuous begins counting from 0 if en=1.
- Simultaneous cfg_wr and apply edge: the apply uses the old shadow. The new write is captured, stays pending and applies at the following boundary.
- Asynchronous rst at any time returns to the reset state, discarding any pending config and any run in progress.

## Timing
- Latency from count change to pulse change is 0: both update on the same edge.
- Period is max+1 cycles and has no dead cycles in continuous mode.
- One-shot: start sampled at edge t → active from t+1 through t+1+max, done at t+2+max. A new start may be sampled on the edge that produces done.
- cfg_err appears one cycle after the rejected cfg_wr.
- Idle apply: cfg_wr at edge t → cfg_pending at t+1 → live config and cfg_ack at t+2.

## Test plan
- Reset, en=1, defaults → count runs 0..10. pulse[0] high at count 2, pulse[1] at 4, pulse[2] at 6, each for 1 cycle. wrap at 10; period 11.
- Mid-period, write max=7, ofs={7,3,0}, wid=2 → live config unchanged until count 10. cfg_ack at the new count 0. pulse[2] at counts 0–1, pulse[1] at 3–4, pulse[0] at 7 only (truncated).
- One-shot config with max=4: pulse start, then pulse start again during RUN → exactly one 5-cycle period, done 1 cycle after count 4, second start ignored.
- cfg_wr with max=5 and offset 6 → cfg_err pulse, cfg_pending stays 0, outputs unaffected.
- en dropped for 3 cycles at count 3 → count held at 3 and pulses low, then resume at 4 with the sequence intact.
- Assert rst at count 5 while a config is pending → all outputs reset immediately, pending cleared, default 11-cycle sequence restarts.
